// File: rtl/load_store_unit_if.sv
// Bundles the execute-request, memory port 1 and writeback signals of the load/store unit.
interface load_store_unit_if #(parameter int WORD_AW = 22);
    logic               req_valid;
    logic               req_ready;
    logic               req_is_store;
    logic [2:0]         req_funct3;
    logic [31:0]        req_addr;
    logic [31:0]        req_wdata;
    logic [4:0]         req_rd;

    logic [WORD_AW-1:0] mem_addr;
    logic               mem_rd_en;
    logic               mem_wr_en;
    logic [31:0]        mem_wdata;
    logic [31:0]        mem_rdata;

    logic               wb_valid;
    logic               wb_ready;
    logic [31:0]        wb_data;
    logic [4:0]         wb_rd;
    logic               wb_fault;

    modport slave (
        input  req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_rd,
        input  mem_rdata, wb_ready,
        output req_ready, mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
        output wb_valid, wb_data, wb_rd, wb_fault
    );

    modport master (
        output req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_rd,
        output mem_rdata, wb_ready,
        input  req_ready, mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
        input  wb_valid, wb_data, wb_rd, wb_fault
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store stage: one request at a time, sub-word stores via read-modify-write on port 1.
// Optional LSU_MISALIGN_TRAP_EN: misaligned accesses skip memory and report wb_fault.
module load_store_unit #(
    parameter int MEM_LATENCY = 1,
    parameter int WORD_AW     = 22
) (
    input  logic              CLK,
    input  logic              rst_n,
    load_store_unit_if.slave  bus
);
    localparam int AW = WORD_AW + 2;
    localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LATENCY - 1);

    typedef enum logic [2:0] {IDLE, READ, MERGE, WRITE, RESP} state_t;

    state_t          state_q, state_d;
    logic            is_store_q, is_store_d;
    logic [2:0]      f3_q, f3_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [4:0]      rd_q, rd_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [31:0]     wword_q, wword_d;
    logic [31:0]     wbdata_q, wbdata_d;
    logic            fault_q, fault_d;
    logic            trap;

    // Address bits above the word index alias; they are deliberately dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.req_addr[31:AW];

    // 0 = byte, 1 = half, 2 = word (unlisted encodings behave as word)
    function automatic logic [1:0] size_of(input logic [2:0] f3);
        logic [1:0] s;
        s = 2'd2;
        case (f3)
            3'b000, 3'b100: s = 2'd0;
            3'b001, 3'b101: s = 2'd1;
            default:        s = 2'd2;
        endcase
        return s;
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
        logic m;
        m = 1'b0;
        case (size_of(f3))
            2'd1:    m = a[0];
            2'd2:    m = (a != 2'b00);
            default: m = 1'b0;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] a,
                                            input logic [2:0] f3);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = w[{a, 3'b000} +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        r = w;
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b100:  r = {24'h0, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b101:  r = {16'h0, h};
            default: r = w;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] w, input logic [1:0] a,
                                          input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] r;
        r = w;
        case (size_of(f3))
            2'd0: r[{a, 3'b000} +: 8] = d[7:0];
            2'd1: if (a[1]) r[31:16] = d[15:0];
                  else      r[15:0]  = d[15:0];
            default: r = d;
        endcase
        return r;
    endfunction

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap = misaligned(bus.req_funct3, bus.req_addr[1:0]);
`else
    assign trap = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        is_store_d = is_store_q;
        f3_d       = f3_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rd_d       = rd_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        wword_d    = wword_q;
        wbdata_d   = wbdata_q;
        fault_d    = fault_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    is_store_d = bus.req_is_store;
                    f3_d       = bus.req_funct3;
                    addr_d     = bus.req_addr[AW-1:0];
                    wdata_d    = bus.req_wdata;
                    rd_d       = bus.req_is_store ? 5'd0 : bus.req_rd;
                    cnt_d      = '0;
                    fault_d    = trap;
                    if (trap) begin
                        wbdata_d = 32'h0;
                        state_d  = RESP;
                    end else if (bus.req_is_store && size_of(bus.req_funct3) == 2'd2) begin
                        wword_d = bus.req_wdata;
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    rdata_d = bus.mem_rdata;
                    if (is_store_q) begin
                        state_d = MERGE;
                    end else begin
                        wbdata_d = extract(bus.mem_rdata, addr_q[1:0], f3_q);
                        state_d  = RESP;
                    end
                end
            end
            MERGE: begin
                wword_d = merge(rdata_q, addr_q[1:0], f3_q, wdata_q);
                state_d = WRITE;
            end
            WRITE: state_d = IDLE;
            RESP:  if (bus.wb_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            is_store_q <= 1'b0;
            f3_q       <= 3'h0;
            addr_q     <= '0;
            wdata_q    <= 32'h0;
            rd_q       <= 5'h0;
            cnt_q      <= '0;
            rdata_q    <= 32'h0;
            wword_q    <= 32'h0;
            wbdata_q   <= 32'h0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
            f3_q       <= f3_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            wword_q    <= wword_d;
            wbdata_q   <= wbdata_d;
            fault_q    <= fault_d;
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.mem_addr  = addr_q[AW-1:2];
    assign bus.mem_rd_en = (state_q == READ) && (cnt_q == '0);
    assign bus.mem_wr_en = (state_q == WRITE);
    assign bus.mem_wdata = wword_q;
    assign bus.wb_valid  = (state_q == RESP);
    assign bus.wb_data   = wbdata_q;
    assign bus.wb_rd     = rd_q;
    // Without the trap build fault_q never leaves 0, so the flag is effectively tied low.
    assign bus.wb_fault  = fault_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboarded bench for load_store_unit with a latency-accurate word memory model.
module tb_load_store_unit;
    localparam int LAT = 3;
    localparam int AW  = 22;
    localparam logic [31:0] GARB = 32'h0BAD_F00D;

    logic CLK = 1'b0;
    logic rst_n = 1'b0;
    always #5 CLK = ~CLK;

    load_store_unit_if #(.WORD_AW(AW)) bus();
    load_store_unit #(.MEM_LATENCY(LAT), .WORD_AW(AW)) dut (.CLK(CLK), .rst_n(rst_n), .bus(bus));

    typedef struct {logic [31:0] data; logic [4:0] rd; logic fault; logic chk_data;} wb_exp_t;
    typedef struct {logic [AW-1:0] addr; logic [31:0] data;} wr_exp_t;
    wb_exp_t wb_q[$];
    wr_exp_t wr_q[$];
    wb_exp_t we;
    wr_exp_t wx;

    int errors = 0, checks = 0, cyc = 0;
    int rd_cnt = 0, wr_cnt = 0, wr_cyc = -1, hs_cyc = -1;

    always @(posedge CLK) cyc <= cyc + 1;

    // Memory: reloaded while in reset; read data valid only LAT-1 cycles after the strobe.
    logic [31:0] mem [16];
    logic        pend;
    int          age;
    logic [3:0]  pa;
    always @(posedge CLK) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
            mem[0] <= 32'h11223344;
            mem[1] <= 32'h8899AABB;
            mem[2] <= 32'h01234567;
            pend   <= 1'b0;
            age    <= 0;
            pa     <= 4'h0;
        end else begin
            if (bus.mem_wr_en) mem[bus.mem_addr[3:0]] <= bus.mem_wdata;
            if (bus.mem_rd_en) begin
                pend <= 1'b1;
                age  <= 1;
                pa   <= bus.mem_addr[3:0];
            end else if (pend) begin
                if (age == LAT - 1) pend <= 1'b0;
                else                age  <= age + 1;
            end
        end
    end
    assign bus.mem_rdata = (LAT == 1) ? (bus.mem_rd_en ? mem[bus.mem_addr[3:0]] : GARB)
                                      : ((pend && age == LAT - 1) ? mem[pa] : GARB);

    // Monitor: pops scoreboards on memory writes and writeback handshakes.
    always @(negedge CLK) begin
        if (rst_n) begin
            if (bus.mem_rd_en) rd_cnt++;
            if (bus.mem_wr_en) begin
                wr_cnt++;
                wr_cyc = cyc;
                checks++;
                if (wr_q.size() == 0) begin
                    errors++;
                    $display("FAIL mem_write unexpected: addr=%0h data=%h", bus.mem_addr, bus.mem_wdata);
                end else begin
                    wx = wr_q.pop_front();
                    if (bus.mem_addr !== wx.addr || bus.mem_wdata !== wx.data) begin
                        errors++;
                        $display("FAIL mem_write: got addr=%0h data=%h want addr=%0h data=%h",
                                 bus.mem_addr, bus.mem_wdata, wx.addr, wx.data);
                    end
                end
            end
            if (bus.wb_valid && bus.wb_ready) begin
                hs_cyc = cyc;
                checks++;
                if (wb_q.size() == 0) begin
                    errors++;
                    $display("FAIL wb unexpected: data=%h rd=%0d fault=%b", bus.wb_data, bus.wb_rd, bus.wb_fault);
                end else begin
                    we = wb_q.pop_front();
                    if (bus.wb_rd !== we.rd || bus.wb_fault !== we.fault ||
                        (we.chk_data && bus.wb_data !== we.data)) begin
                        errors++;
                        $display("FAIL wb: got data=%h rd=%0d fault=%b want data=%h rd=%0d fault=%b",
                                 bus.wb_data, bus.wb_rd, bus.wb_fault, we.data, we.rd, we.fault);
                    end
                end
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [4:0] rd, output int acc);
        logic ok;
        bus.req_is_store = st;
        bus.req_funct3   = f3;
        bus.req_addr     = a;
        bus.req_wdata    = wd;
        bus.req_rd       = rd;
        bus.req_valid    = 1'b1;
        acc = -1;
        for (int n = 0; n < 100; n++) begin
            @(negedge CLK);
            ok = bus.req_ready;
            @(posedge CLK);
            #1;
            if (ok) begin
                acc = cyc - 1;
                break;
            end
        end
        bus.req_valid = 1'b0;
        if (acc < 0) begin
            checks++;
            errors++;
            $display("FAIL accept timeout: addr=%h", a);
        end
    endtask

    task automatic wait_wb(output int c);
        c = -1;
        for (int n = 0; n < 50; n++) begin
            @(negedge CLK);
            if (bus.wb_valid) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) begin
            checks++;
            errors++;
            $display("FAIL wb_valid timeout");
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 100; n++) begin
            if (wb_q.size() == 0 && wr_q.size() == 0) break;
            wait_cycles(1);
        end
        checks++;
        if (wb_q.size() != 0 || wr_q.size() != 0) begin
            errors++;
            $display("FAIL drain: wb pending=%0d wr pending=%0d want 0", wb_q.size(), wr_q.size());
        end
        wait_cycles(1);
    endtask

    task automatic test_reset();
        wait_cycles(3);
        checks++;
        if ({bus.req_ready, bus.mem_rd_en, bus.mem_wr_en, bus.wb_valid, bus.wb_fault} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 10000",
                     {bus.req_ready, bus.mem_rd_en, bus.mem_wr_en, bus.wb_valid, bus.wb_fault});
        end
        checks++;
        if (bus.mem_addr !== '0 || bus.mem_wdata !== 32'h0 || bus.wb_data !== 32'h0 || bus.wb_rd !== 5'h0) begin
            errors++;
            $display("FAIL reset_data: addr=%h wdata=%h wb_data=%h wb_rd=%0d want 0",
                     bus.mem_addr, bus.mem_wdata, bus.wb_data, bus.wb_rd);
        end
        rst_n = 1'b1;
        wait_cycles(1);
    endtask

    task automatic test_loads();
        int a;
        wb_q.push_back('{32'hFFFFFF88, 5'd1, 1'b0, 1'b1});
        send(1'b0, 3'b000, 32'h7, 32'h0, 5'd1, a);
        wb_q.push_back('{32'h00000088, 5'd2, 1'b0, 1'b1});
        send(1'b0, 3'b100, 32'h7, 32'h0, 5'd2, a);
        wb_q.push_back('{32'hFFFFAABB, 5'd3, 1'b0, 1'b1});
        send(1'b0, 3'b001, 32'h4, 32'h0, 5'd3, a);
        wb_q.push_back('{32'h00008899, 5'd4, 1'b0, 1'b1});
        send(1'b0, 3'b101, 32'h6, 32'h0, 5'd4, a);
        // Upper address bits alias onto the same word.
        wb_q.push_back('{32'h8899AABB, 5'd5, 1'b0, 1'b1});
        send(1'b0, 3'b010, 32'hF000_0004, 32'h0, 5'd5, a);
        drain();
    endtask

    task automatic test_subword_store();
        int a, w0, r0;
        w0 = wr_cnt;
        r0 = rd_cnt;
        wr_q.push_back('{22'd1, 32'h889912BB});
        send(1'b1, 3'b000, 32'h5, 32'hFFFF_FF12, 5'd9, a);
        wr_q.push_back('{22'd1, 32'hCAFE12BB});
        send(1'b1, 3'b001, 32'h6, 32'h1234_CAFE, 5'd9, a);
        drain();
        checks++;
        if (wr_cnt - w0 != 2 || rd_cnt - r0 != 2) begin
            errors++;
            $display("FAIL subword_counts: writes=%0d reads=%0d want 2 2", wr_cnt - w0, rd_cnt - r0);
        end
    endtask

    task automatic test_sw();
        int a, r0;
        r0 = rd_cnt;
        wr_q.push_back('{22'd2, 32'hDEADBEEF});
        send(1'b1, 3'b010, 32'h8, 32'hDEADBEEF, 5'd9, a);
        drain();
        checks++;
        if (wr_cyc != a + 1 || rd_cnt != r0) begin
            errors++;
            $display("FAIL sw_timing: write delay=%0d reads=%0d want 1 0", wr_cyc - a, rd_cnt - r0);
        end
    endtask

    task automatic test_latency();
        int a, c;
        wb_q.push_back('{32'hDEADBEEF, 5'd9, 1'b0, 1'b1});
        send(1'b0, 3'b010, 32'h8, 32'h0, 5'd9, a);
        wait_wb(c);
        checks++;
        if (c - a != LAT + 1) begin
            errors++;
            $display("FAIL latency: got %0d want %0d", c - a, LAT + 1);
        end
        drain();
    endtask

    task automatic test_hold();
        int a, c;
        bus.wb_ready = 1'b0;
        wb_q.push_back('{32'hCAFE12BB, 5'd10, 1'b0, 1'b1});
        send(1'b0, 3'b010, 32'h4, 32'h0, 5'd10, a);
        wait_wb(c);
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (bus.wb_valid !== 1'b1 || bus.wb_data !== 32'hCAFE12BB || bus.req_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold[%0d]: valid=%b data=%h ready=%b want 1 cafe12bb 0",
                         k, bus.wb_valid, bus.wb_data, bus.req_ready);
            end
            @(negedge CLK);
        end
        @(posedge CLK);
        #1;
        bus.wb_ready = 1'b1;
        drain();
    endtask

    task automatic test_misalign();
        int a, r0, w0;
        r0 = rd_cnt;
        w0 = wr_cnt;
`ifdef LSU_MISALIGN_TRAP_EN
        wb_q.push_back('{32'h0, 5'd11, 1'b1, 1'b1});
        send(1'b0, 3'b010, 32'h2, 32'h0, 5'd11, a);
        wb_q.push_back('{32'h0, 5'd0, 1'b1, 1'b0});
        send(1'b1, 3'b010, 32'hA, 32'h55AA55AA, 5'd11, a);
        drain();
        checks++;
        if (rd_cnt != r0 || wr_cnt != w0) begin
            errors++;
            $display("FAIL misalign_trap: reads=%0d writes=%0d want 0 0", rd_cnt - r0, wr_cnt - w0);
        end
`else
        wb_q.push_back('{32'h11223344, 5'd11, 1'b0, 1'b1});
        send(1'b0, 3'b010, 32'h2, 32'h0, 5'd11, a);
        wr_q.push_back('{22'd2, 32'h55AA55AA});
        send(1'b1, 3'b010, 32'hA, 32'h55AA55AA, 5'd11, a);
        drain();
        checks++;
        if (rd_cnt - r0 != 1 || wr_cnt - w0 != 1) begin
            errors++;
            $display("FAIL misalign_plain: reads=%0d writes=%0d want 1 1", rd_cnt - r0, wr_cnt - w0);
        end
`endif
    endtask

    task automatic test_back_to_back();
        int a1, a2;
        logic [31:0] m2;
`ifdef LSU_MISALIGN_TRAP_EN
        m2 = 32'hDEADBEEF;
`else
        m2 = 32'h55AA55AA;
`endif
        wb_q.push_back('{32'h11223344, 5'd3, 1'b0, 1'b1});
        wb_q.push_back('{m2, 5'd7, 1'b0, 1'b1});
        send(1'b0, 3'b010, 32'h0, 32'h0, 5'd3, a1);
        send(1'b0, 3'b010, 32'h8, 32'h0, 5'd7, a2);
        checks++;
        if (hs_cyc <= a1 || a2 != hs_cyc + 1) begin
            errors++;
            $display("FAIL back_to_back: second accept=%0d first handshake=%0d want accept=handshake+1",
                     a2, hs_cyc);
        end
        drain();
    endtask

    task automatic test_reset_mid_store();
        int a, w0;
        w0 = wr_cnt;
        send(1'b1, 3'b000, 32'h5, 32'h77, 5'd0, a);
        checks++;
        if (bus.mem_rd_en !== 1'b1) begin
            errors++;
            $display("FAIL abort_in_read: mem_rd_en=%b want 1", bus.mem_rd_en);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.req_ready, bus.mem_rd_en, bus.mem_wr_en, bus.wb_valid} !== 4'b1000 || bus.mem_addr !== '0) begin
            errors++;
            $display("FAIL abort_reset: ctrl=%b addr=%h want 1000 0",
                     {bus.req_ready, bus.mem_rd_en, bus.mem_wr_en, bus.wb_valid}, bus.mem_addr);
        end
        wait_cycles(3);
        rst_n = 1'b1;
        wait_cycles(6);
        checks++;
        if (wr_cnt != w0 || bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_after: writes=%0d ready=%b want 0 1", wr_cnt - w0, bus.req_ready);
        end
        wb_q.push_back('{32'h00000045, 5'd12, 1'b0, 1'b1});
        send(1'b0, 3'b100, 32'h9, 32'h0, 5'd12, a);
        drain();
    endtask

    initial begin
        bus.req_valid    = 1'b0;
        bus.req_is_store = 1'b0;
        bus.req_funct3   = 3'b000;
        bus.req_addr     = 32'h0;
        bus.req_wdata    = 32'h0;
        bus.req_rd       = 5'd0;
        bus.wb_ready     = 1'b1;
        test_reset();
        test_loads();
        test_subword_store();
        test_sw();
        test_latency();
        test_hold();
        test_misalign();
        test_back_to_back();
        test_reset_mid_store();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage between the execute stage and the dual-port word-addressed data memory; drives memory port 1.
- Accepts one load/store request at a time from execute.
- For stores: converts byte addresses to word index and byte lanes, merging sub-word data with a read-modify-write.
- For loads: extracts and sign/zero-extends the result and hands it to writeback with a valid/ready handshake.

Parameters:
MEM_LATENCY, 1, cycles from mem_rd_en to valid mem_rdata (legal 1..4)
WORD_AW, 22, word-index width (4M x 32 memory)

Ports:
CLK  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  execute presents a request
req_ready  output  1  unit can accept a request
req_is_store  input  1  1 = store, 0 = load
req_funct3  input  3  000 B, 001 H, 010 W, 100 BU, 101 HU
req_addr  input  32  byte address
req_wdata  input  32  store data (right-aligned)
req_rd  input  5  load destination register
mem_addr  output  WORD_AW  word index = req_addr[WORD_AW+1:2]
mem_rd_en  output  1  read strobe
mem_wr_en  output  1  write strobe, full word
mem_wdata  output  32  merged write word
mem_rdata  input  32  raw word from memory
wb_valid  output  1  load result / fault available
wb_ready  input  1  writeback accepts
wb_data  output  32  extended load data
wb_rd  output  5  destination register
wb_fault  output  1  misaligned access flag

Behaviour:
- Reset values: all outputs 0, except req_ready = 1. FSM in IDLE.
- Reset mid-operation aborts immediately; no memory write is issued after rst_n falls.
- FSM states: IDLE, READ, MERGE, WRITE, RESP.
- IDLE:
  - req_ready = 1. A request is accepted on req_valid && req_ready; all request fields are latched at acceptance.
  - LW / LB / LH / LBU / LHU go to READ.
  - SW goes directly to WRITE, with mem_wdata = req_wdata.
  - SB / SH go to READ, then MERGE.
- READ:
  - mem_rd_en pulses 1 cycle.
  - A latency counter counts MEM_LATENCY cycles, then mem_rdata is captured.
  - Loads then go to RESP; sub-word stores go to MERGE.
- MERGE (1 cycle): the addressed lanes of the captured word are replaced with the store data; then go to WRITE.
  - SB: lane = addr[1:0], byte = wdata[7:0].
  - SH: lanes {addr[1],0} and {addr[1],1}, half = wdata[15:0].
- WRITE: mem_wr_en = 1 for exactly 1 cycle, then IDLE. Stores produce no writeback.
- RESP:
  - wb_valid held with wb_data / wb_rd / wb_fault stable until wb_ready; return to IDLE on the handshake cycle.
  - req_ready = 0 in every state except IDLE.
- Load extraction: the byte/half is selected by addr[1:0] / addr[1].
  - LB / LH sign-extend from bit 7 / bit 15 of the selected field.
  - LBU / LHU zero-extend.
  - LW passes the word unchanged.
  - Unlisted funct3 values are treated as W.
- Back-to-back: the earliest next acceptance is the cycle after return to IDLE. Latency from acceptance to wb_valid is MEM_LATENCY+1 cycles (1 + MEM_LATENCY when wb_ready is tied high).
- Misalignment: H with addr[0]=1, or W with addr[1:0]≠0; handling is per the optional feature.
- Address wrap: bits above WORD_AW+1 are ignored (aliasing).

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN
- Defined:
  - A misaligned load goes IDLE→RESP with no memory access, wb_fault = 1, wb_data = 0.
  - A misaligned store performs no memory access; it goes to RESP with wb_fault = 1 and wb_rd = 0.
- Undefined:
  - wb_fault is tied 0.
  - Misaligned H uses lanes {addr[1],0..1}; misaligned W uses the whole word (low bits ignored).
  - Stores never enter RESP.

Test Plan:
- Word at index 1 = 0x8899AABB, LB addr 0x7 → wb_data 0xFFFFFF88; LBU addr 0x7 → 0x00000088; LH addr 0x4 → 0xFFFFAABB; LHU addr 0x6 → 0x00008899.
- SB wdata 0x12 to addr 0x5 over 0x8899AABB → exactly one mem_wr_en, mem_wdata 0x889912BB. SW addr 0x8 wdata 0xDEADBEEF → mem_wr_en one cycle after acceptance, no mem_rd_en.
- MEM_LATENCY=3, LW with wb_ready=1 → wb_valid exactly 4 cycles after acceptance; wb_ready=0 for 5 cycles → wb_valid and wb_data held, req_ready=0 throughout.
- With the macro defined, LW addr 0x2 → no mem_rd_en/mem_wr_en, wb_fault=1, wb_data=0. Without it → reads word 0, wb_fault=0.
- Assert rst_n low during READ of an SB → outputs return to reset values immediately; no mem_wr_en afterwards; req_ready=1 after release.
- Two back-to-back LW requests held on req_valid → second accepted only after the first wb handshake; results in order with correct wb_rd.
